// File: rtl/mp_add_seq_12_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer: chunk width,
// FSM state encodings and the chunk-index width helper.
package mp_add_seq_12_pkg;

    localparam int W_CHUNK = 12;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Chunk counter width; a single-chunk operand still needs a 1-bit counter.
    function automatic int idx_bits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_12_adder.sv
// Combinational 12-bit chunk adder with carry in/out.
// Zero latency; no flow control.
module tree_12_adder
    import mp_add_seq_12_pkg::*;
(
    input  logic [W_CHUNK-1:0] x,
    input  logic [W_CHUNK-1:0] y,
    input  logic               cin,
    output logic [W_CHUNK-1:0] sum,
    output logic               cout
);

    logic [W_CHUNK:0] total;

    assign total       = {1'b0, x} + {1'b0, y} + {{W_CHUNK{1'b0}}, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/mp_add_seq_12.sv
// Multi-precision add/subtract, one 12-bit chunk per cycle LSB first; result WORDS+1 cycles after accept.
// One op in flight: in_ready low through RUN and DONE; result held in DONE until out_ready.
module mp_add_seq_12
    import mp_add_seq_12_pkg::*;
#(
    parameter int WORDS = 4
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W_CHUNK*WORDS-1:0]   in_a,
    input  logic [W_CHUNK*WORDS-1:0]   in_b,
    input  logic                       in_cin,
    input  logic                       in_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W_CHUNK*WORDS-1:0]   out_sum,
    output logic                       out_cout,
    output logic                       out_ovf
);

    localparam int W  = W_CHUNK;
    localparam int N  = W * WORDS;
    localparam int IW = idx_bits(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  sum_q;

    logic [W-1:0]  x_chunk;
    logic [W-1:0]  y_chunk;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic [N-1:0]  next_sum;

    assign x_chunk = a_q[idx*W +: W];
    assign y_chunk = b_q[idx*W +: W];

    tree_12_adder u_adder (
        .x    (x_chunk),
        .y    (y_chunk),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Partial result with the current chunk merged in; on the last chunk this is the full sum.
    always_comb begin
        next_sum = sum_q;
        next_sum[idx*W +: W] = add_sum;
    end

    assign in_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        // Subtraction runs as A + ~B + 1; carry-in is forced and in_cin ignored.
                        b_q   <= in_sub ? ~in_b : in_b;
                        carry <= in_sub ? 1'b1 : in_cin;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q <= next_sum;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        out_sum   <= next_sum;
                        out_cout  <= add_cout;
                        out_ovf   <= (a_q[N-1] == b_q[N-1]) && (next_sum[N-1] != a_q[N-1]);
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq_12.sv
// Randomized and directed bench for mp_add_seq_12 (WORDS=4, 48-bit operands).
module tb_mp_add_seq_12;

    typedef struct packed {
        logic [47:0] s;
        logic        c;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_a;
    logic [47:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mp_add_seq_12 #(.WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Reference: exact signed and unsigned integer arithmetic on the whole operands.
    function automatic res_t model(input logic [47:0] a, input logic [47:0] b,
                                   input logic cin, input logic sub);
        longint          sa, sb, ex;
        longint unsigned ua, ub, tot;
        res_t            r;
        sa = $signed({{16{a[47]}}, a});
        sb = $signed({{16{b[47]}}, b});
        ua = {16'h0, a};
        ub = {16'h0, b};
        if (sub) begin
            ex  = sa - sb;
            tot = ua - ub;
            r.c = (ua >= ub);
        end else begin
            ex  = sa + sb + (cin ? 64'sd1 : 64'sd0);
            tot = ua + ub + {63'b0, cin};
            r.c = (tot >= 64'h0001_0000_0000_0000);
        end
        r.s = tot[47:0];
        r.o = (ex > 64'sh7FFF_FFFF_FFFF) || (ex < -64'sh8000_0000_0000);
        return r;
    endfunction

    function automatic logic [47:0] rand_op();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: return 48'h0;
            1: return 48'hFFFF_FFFF_FFFF;
            2: return 48'h8000_0000_0000;
            3: return 48'h7FFF_FFFF_FFFF;
            default: return r[47:0];
        endcase
    endfunction

    task automatic send(input logic [47:0] a, input logic [47:0] b, input logic c, input logic s);
        int n = 0;
        in_a = a; in_b = b; in_cin = c; in_sub = s; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(output res_t r, output int lat);
        lat = 1;
        out_ready = 1'b1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        r = {out_sum, out_cout, out_ovf};
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL recv_timeout out_valid=%b required 1", out_valid);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_sum, out_cout, out_ovf} !== 52'h0) begin
            n_bad++;
            $display("FAIL reset_state got rdy=%b vld=%b sum=%h c=%b o=%b required all 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        res_t r;
        int   lat;
        send(48'h0000_0000_0FFF, 48'h0000_0000_0001, 1'b0, 1'b0);
        recv(r, lat);
        n_vec++;
        if (r !== {48'h0000_0000_1000, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL add_basic got %h required %h", r, {48'h0000_0000_1000, 2'b00});
        end
        n_vec++;
        if (lat !== 5) begin
            n_bad++; $display("FAIL add_latency got %0d required 5", lat);
        end
        send(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0);
        recv(r, lat);
        n_vec++;
        if (r !== {48'h0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL ripple got %h required %h", r, {48'h0, 2'b10});
        end
        send(48'h0000_0000_0005, 48'h0000_0000_0007, 1'b1, 1'b1);
        recv(r, lat);
        n_vec++;
        if (r !== {48'hFFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL sub_borrow got %h required %h", r, {48'hFFFF_FFFF_FFFE, 2'b00});
        end
        send(48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0);
        recv(r, lat);
        n_vec++;
        if (r !== {48'h8000_0000_0000, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL add_ovf got %h required %h", r, {48'h8000_0000_0000, 2'b01});
        end
        send(48'h8000_0000_0000, 48'h0000_0000_0001, 1'b0, 1'b1);
        recv(r, lat);
        n_vec++;
        if (r !== {48'h7FFF_FFFF_FFFF, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL sub_ovf got %h required %h", r, {48'h7FFF_FFFF_FFFF, 2'b11});
        end
    endtask

    task automatic test_backpressure();
        res_t        r, held, exp2;
        int          n = 0;
        int          lat;
        logic [47:0] a2, b2;
        send(48'h0123_4567_89AB, 48'h0FED_CBA9_8765, 1'b1, 1'b0);
        out_ready = 1'b0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        held = {out_sum, out_cout, out_ovf};
        n_vec++;
        if (held !== model(48'h0123_4567_89AB, 48'h0FED_CBA9_8765, 1'b1, 1'b0)) begin
            n_bad++; $display("FAIL bp_first got %h required %h", held,
                              model(48'h0123_4567_89AB, 48'h0FED_CBA9_8765, 1'b1, 1'b0));
        end
        a2 = rand_op(); b2 = rand_op();
        exp2 = model(a2, b2, 1'b0, 1'b1);
        in_a = a2; in_b = b2; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({out_valid, in_ready, out_sum, out_cout, out_ovf} !== {2'b10, held}) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b res=%h required vld=1 rdy=0 res=%h",
                         i, out_valid, in_ready, {out_sum, out_cout, out_ovf}, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL bp_release got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_accept got rdy=%b required 0", in_ready);
        end
        recv(r, lat);
        n_vec++;
        if (r !== exp2) begin
            n_bad++; $display("FAIL bp_second got %h required %h", r, exp2);
        end
    endtask

    task automatic test_reset_mid_op();
        res_t r;
        int   lat;
        send(48'hAAAA_BBBB_CCCC, 48'h5555_4444_3333, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_bad++; $display("FAIL rst_run_async got vld=%b rdy=%b required 0 0", out_valid, in_ready);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({in_ready, out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 51'h0}) begin
            n_bad++;
            $display("FAIL rst_run_after got rdy=%b vld=%b sum=%h c=%b o=%b required rdy=1 rest 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf);
        end
        // Abort during DONE as well
        send(48'hFFFF_0000_FFFF, 48'h0001_0000_0001, 1'b0, 1'b0);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, out_sum} !== 49'h0) begin
            n_bad++; $display("FAIL rst_done_async got vld=%b sum=%h required 0 0", out_valid, out_sum);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send(48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, 1'b0);
        recv(r, lat);
        n_vec++;
        if (r !== {48'h2345_6789_ABCD, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rst_follow_op got %h required %h", r, {48'h2345_6789_ABCD, 2'b00});
        end
    endtask

    task automatic test_random();
        res_t        r, e;
        int          lat;
        logic [47:0] a, b;
        logic        c, s;
        for (int i = 0; i < 30; i++) begin
            a = rand_op(); b = rand_op();
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            e = model(a, b, c, s);
            send(a, b, c, s);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            recv(r, lat);
            n_vec++;
            if (r !== e) begin
                n_bad++;
                $display("FAIL random i=%0d a=%h b=%h cin=%b sub=%b got %h required %h", i, a, b, c, s, r, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t        q[$];
        res_t        e, r;
        logic [47:0] a, b;
        logic        c, s;
        int          last = -1;
        int          issued = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (out_valid) begin
                r = {out_sum, out_cout, out_ovf};
                e = (q.size() > 0) ? q.pop_front() : '0;
                n_vec++;
                if (r !== e) begin
                    n_bad++; $display("FAIL b2b_result cyc=%0d got %h required %h", cyc, r, e);
                end
            end
            if (cyc >= 70) in_valid = 1'b0;
            if (in_ready && in_valid) begin
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last !== 6) begin
                        n_bad++; $display("FAIL b2b_gap cyc=%0d got %0d required 6", cyc, cyc - last);
                    end
                end
                last = cyc;
                a = rand_op(); b = rand_op();
                c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
                in_a = a; in_b = b; in_cin = c; in_sub = s;
                q.push_back(model(a, b, c, s));
                issued++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_vec++;
        if (q.size() !== 0 || issued < 10) begin
            n_bad++; $display("FAIL b2b_drain got pending=%0d issued=%0d required pending=0 issued>=10",
                              q.size(), issued);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
